// File: rtl/aesl_deadlock_report_ctrl.sv
// Deadlock report sequencer: debounces the monitor's block flag, snapshots per-channel
// block codes and streams one record per blocked channel. Optional macro AESL_DEADLOCK_STAMP_EN adds rpt_stamp.
module aesl_deadlock_report_ctrl #(
  parameter int NUM_CH         = 2,
  parameter int CH_W           = 2,
  parameter int CONFIRM_CYCLES = 1024,
  parameter int CNT_W          = 16,
  localparam int IDX_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   block_in,
  input  logic [NUM_CH*CH_W-1:0] axis_block_info,
  input  logic                   clear,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [IDX_W-1:0]       rpt_ch,
  output logic [CH_W-1:0]        rpt_code,
`ifdef AESL_DEADLOCK_STAMP_EN
  output logic [31:0]            rpt_stamp,
`endif
  output logic                   deadlock,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUSPECT,
    S_CONFIRM,
    S_REPORT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_CH - 1);

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [NUM_CH*CH_W-1:0]   r_snap;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_rpt_valid;
  logic [IDX_W-1:0]         r_rpt_ch;
  logic [CH_W-1:0]          r_rpt_code;
  logic                     r_deadlock;
  logic                     r_busy;

  logic                     w_blocked;
  logic                     w_enter_confirm;
  logic [CH_W-1:0]          w_cur_code;
  logic                     w_last;

  always_comb begin
    w_blocked       = enable & block_in;
    w_enter_confirm = 1'b0;
    if (r_state == S_IDLE)
      w_enter_confirm = w_blocked && (CONFIRM_CYCLES == 1);
    else if (r_state == S_SUSPECT)
      w_enter_confirm = w_blocked && (r_cnt >= C_LAST);
    w_cur_code = r_snap[int'(r_idx)*CH_W +: CH_W];
    w_last     = (r_idx == I_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_snap      <= '0;
      r_idx       <= '0;
      r_rpt_valid <= 1'b0;
      r_rpt_ch    <= '0;
      r_rpt_code  <= '0;
      r_deadlock  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_enter_confirm) begin
            r_state <= S_CONFIRM;
            r_snap  <= axis_block_info;
            r_cnt   <= C_LAST;
            r_busy  <= 1'b1;
          end else if (w_blocked) begin
            r_state <= S_SUSPECT;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        S_SUSPECT: begin
          if (!w_blocked) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_enter_confirm) begin
            r_state <= S_CONFIRM;
            r_snap  <= axis_block_info;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CONFIRM: begin
          r_deadlock <= 1'b1;
          r_idx      <= '0;
          r_state    <= S_REPORT;
        end
        S_REPORT: begin
          // A record is loaded one cycle after its channel is reached, so rpt_valid
          // stays a pure register and only falls on a completed handshake.
          if (r_rpt_valid) begin
            if (rpt_ready) begin
              r_rpt_valid <= 1'b0;
              if (w_last) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end else if (w_cur_code != '0) begin
            r_rpt_valid <= 1'b1;
            r_rpt_ch    <= r_idx;
            r_rpt_code  <= w_cur_code;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_rpt_valid <= 1'b0;
          if (clear) begin
            r_state    <= S_IDLE;
            r_deadlock <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AESL_DEADLOCK_STAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_stamp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle <= '0;
      r_stamp <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (w_enter_confirm)
        r_stamp <= r_cycle;
    end
  end

  assign rpt_stamp = r_stamp;
`endif

  assign rpt_valid = r_rpt_valid;
  assign rpt_ch    = r_rpt_ch;
  assign rpt_code  = r_rpt_code;
  assign deadlock  = r_deadlock;
  assign busy      = r_busy;

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Directed bench for aesl_deadlock_report_ctrl (NUM_CH=2, CH_W=2, CONFIRM_CYCLES=4).
module tb_aesl_deadlock_report_ctrl;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       block_in;
  logic [3:0] info;
  logic       clear;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [0:0] rpt_ch;
  logic [1:0] rpt_code;
  logic       deadlock;
  logic       busy;
`ifdef AESL_DEADLOCK_STAMP_EN
  logic [31:0] rpt_stamp;
`endif

  int errors = 0;
  int checks = 0;

  int         n_xfer = 0;
  logic [0:0] rec_ch   [0:15];
  logic [1:0] rec_code [0:15];

  aesl_deadlock_report_ctrl #(
    .NUM_CH         (2),
    .CH_W           (2),
    .CONFIRM_CYCLES (4),
    .CNT_W          (16)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .block_in        (block_in),
    .axis_block_info (info),
    .clear           (clear),
    .rpt_valid       (rpt_valid),
    .rpt_ready       (rpt_ready),
    .rpt_ch          (rpt_ch),
    .rpt_code        (rpt_code),
`ifdef AESL_DEADLOCK_STAMP_EN
    .rpt_stamp       (rpt_stamp),
`endif
    .deadlock        (deadlock),
    .busy            (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (reset_n && rpt_valid && rpt_ready) begin
      rec_ch[n_xfer[3:0]]   = rpt_ch;
      rec_code[n_xfer[3:0]] = rpt_code;
      n_xfer++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", {31'd0, busy}, 32'd0);
  endtask

  int base;

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    block_in  = 1'b0;
    info      = 4'b0000;
    clear     = 1'b0;
    rpt_ready = 1'b0;
    #2;
    chk("rst_valid",    rpt_valid, 0);
    chk("rst_ch",       rpt_ch,    0);
    chk("rst_code",     rpt_code,  0);
    chk("rst_deadlock", deadlock,  0);
    chk("rst_busy",     busy,      0);
    #10 reset_n = 1'b1;
    tick();

    // Glitch: three high samples then low
    block_in = 1'b1;
    tick();
    chk("glitch_busy1", busy, 1);
    tick(2);
    chk("glitch_dl_3", deadlock, 0);
    chk("glitch_busy3", busy, 1);
    block_in = 1'b0;
    tick();
    chk("glitch_busy_back", busy, 0);
    chk("glitch_dl", deadlock, 0);
    chk("glitch_valid", rpt_valid, 0);
    tick(2);
    chk("glitch_valid2", rpt_valid, 0);

    // Confirm with backpressure on first record, info=1110
    base     = n_xfer;
    info     = 4'b1110;
    block_in = 1'b1;
    tick(3);
    chk("conf_dl_before", deadlock, 0);
    tick();
    chk("conf_edge_busy", busy, 1);
    chk("conf_edge_dl", deadlock, 0);
    block_in = 1'b0;
    tick();
    chk("conf_dl_set", deadlock, 1);
    chk("conf_valid0", rpt_valid, 0);
    tick();
    chk("rec0_valid", rpt_valid, 1);
    chk("rec0_ch", rpt_ch, 0);
    chk("rec0_code", rpt_code, 2'b10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", rpt_valid, 1);
      chk("bp_ch", rpt_ch, 0);
      chk("bp_code", rpt_code, 2'b10);
    end
    rpt_ready = 1'b1;
    tick();
    chk("xfer0_valid", rpt_valid, 0);
    tick();
    chk("rec1_valid", rpt_valid, 1);
    chk("rec1_ch", rpt_ch, 1);
    chk("rec1_code", rpt_code, 2'b11);
    tick();
    chk("done_valid", rpt_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_dl", deadlock, 1);
    chk("conf_xfers", n_xfer - base, 2);
    chk("conf_x0_ch", rec_ch[base[3:0]], 0);
    chk("conf_x0_code", rec_code[base[3:0]], 2'b10);
    chk("conf_x1_ch", rec_ch[4'(base + 1)], 1);
    chk("conf_x1_code", rec_code[4'(base + 1)], 2'b11);
    tick(3);
    chk("done_hold_dl", deadlock, 1);
    chk("done_hold_xfers", n_xfer - base, 2);

    // Skip: info=1100 yields only channel 1
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_dl", deadlock, 0);
    base     = n_xfer;
    info     = 4'b1100;
    block_in = 1'b1;
    tick(4);
    block_in = 1'b0;
    wait_idle(20);
    chk("skip_xfers", n_xfer - base, 1);
    chk("skip_ch", rec_ch[base[3:0]], 1);
    chk("skip_code", rec_code[base[3:0]], 2'b11);
    chk("skip_dl", deadlock, 1);

    // Empty snapshot: no records, deadlock still declared
    clear = 1'b1;
    tick();
    clear = 1'b0;
    base     = n_xfer;
    info     = 4'b0000;
    block_in = 1'b1;
    tick(4);
    block_in = 1'b0;
    wait_idle(20);
    chk("empty_xfers", n_xfer - base, 0);
    chk("empty_dl", deadlock, 1);
    chk("empty_valid", rpt_valid, 0);

    // Clear with block held high, then retrigger; clear in SUSPECT ignored
    info      = 4'b1110;
    rpt_ready = 1'b0;
    block_in  = 1'b1;
    clear     = 1'b1;
    tick();
    clear = 1'b0;
    chk("retrig_dl_clr", deadlock, 0);
    chk("retrig_busy_idle", busy, 0);
    tick();
    chk("retrig_suspect", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_in_suspect_busy", busy, 1);
    tick(2);
    chk("retrig_conf_dl0", deadlock, 0);
    tick();
    chk("retrig_dl1", deadlock, 1);
    tick();
    chk("retrig_valid", rpt_valid, 1);
    chk("retrig_code", rpt_code, 2'b10);

    // Async reset mid-REPORT
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid",    rpt_valid, 0);
    chk("arst_ch",       rpt_ch,    0);
    chk("arst_code",     rpt_code,  0);
    chk("arst_deadlock", deadlock,  0);
    chk("arst_busy",     busy,      0);
    block_in = 1'b0;
    #10 reset_n = 1'b1;
    tick(2);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", rpt_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
